mixer_decimator: RTL and testbench
==================================

MIXER_DECIMATOR -- requirements
Module: mixer_decimator

Interface
REQ-001 The block SHALL have parameter WIDTH_IN, default 42, giving the signed input width, equal to the full product width of a 24x18 mixer.
REQ-002 The block SHALL have parameter WIDTH_OUT, default 32, giving the signed output width; the block SHALL require WIDTH_OUT <= WIDTH_IN.
REQ-003 The block SHALL have parameter LOG2_MAX_DECIM, default 16, giving the maximum log2 of the decimation ratio.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port data_i, input, signed [WIDTH_IN-1:0]: mixer product sample.
REQ-007 The block SHALL have port valid_i, input, 1 bit: data_i is qualified this cycle.
REQ-008 The block SHALL have port log2_decim_i, input, [4:0]: log2 of the decimation ratio N.
REQ-009 The block SHALL have port clear_i, input, 1 bit: synchronous flush of the current block.
REQ-010 The block SHALL have port data_o, output, signed [WIDTH_OUT-1:0]: decimated average.
REQ-011 The block SHALL have port valid_o, output, 1 bit: one-cycle strobe marking a new data_o.

Function
REQ-012 The block SHALL have two states: ACCUM (summing samples) and DUMP (one cycle, presenting the result); ACCUM->DUMP SHALL occur on the N-th accepted sample; DUMP->ACCUM SHALL occur unconditionally.
REQ-013 The block SHALL use an accumulator of WIDTH_IN+LOG2_MAX_DECIM bits, sign-extended, that never overflows.
REQ-014 The block SHALL latch N = 2^min(log2_decim_i, LOG2_MAX_DECIM) on the first accepted sample of each block; changes to log2_decim_i mid-block SHALL take effect at the next block.
REQ-015 The result SHALL be (sum of N samples) >>> log2 N (arithmetic shift), then bits [WIDTH_IN-1 -: WIDTH_OUT] (the LSBs dropped).
REQ-016 The block SHALL register data_o and valid_o; valid_o SHALL be high for exactly 1 cycle, in the cycle after the edge that accepted the N-th sample.
REQ-017 data_o SHALL hold its value until the next valid_o.
REQ-018 A valid_i in the DUMP cycle SHALL be accepted as the first sample of the next block, so that no samples are dropped at full rate.
REQ-019 With log2 N = 0, every accepted sample SHALL produce a valid_o one cycle later, so back-to-back valid_i gives continuous valid_o.
REQ-020 clear_i SHALL zero the counter and the accumulator, return the state to ACCUM and suppress any valid_o due next cycle; a valid_i in the same cycle as clear_i SHALL be discarded; data_o SHALL keep its last value.
REQ-021 Cycles with valid_i low SHALL leave all state unchanged.

Reset
REQ-022 On rst_ni low, the block SHALL, asynchronously: state=ACCUM, counter=0, accumulator=0, latched N=1, data_o=0, valid_o=0.
REQ-023 Reset asserted mid-block SHALL discard the partial sum; the first valid_i after release SHALL start a new block.

Configuration
REQ-024 When macro MIXER_DECIMATOR_ROUND_EN is defined, before the bits are dropped the block SHALL add 2^(WIDTH_IN-WIDTH_OUT-1) (round half up) and saturate to the WIDTH_OUT signed range; latency SHALL be unchanged.
REQ-025 When MIXER_DECIMATOR_ROUND_EN is not defined, the block SHALL truncate (floor) and perform no saturation.

Structure
REQ-026 The state encoding (ACCUM, DUMP) and the accumulator width function SHALL live in package mixer_decimator_pkg.
REQ-027 The round/saturate/slice logic SHALL be a sub-module named decim_round, instantiated in both configurations (pass-through truncation without the macro).

Verification
REQ-028 Test 1: log2=2, four valid samples of 5120 -> one valid_o pulse, data_o=5, one cycle after the 4th sample.
REQ-029 Test 2: log2=2, four samples of -5120 -> data_o=-5.
REQ-030 Test 3: log2=0, input 1536 -> data_o=1 without the macro and 2 with it; input -1536 -> -2 without the macro and -1 with it.
REQ-031 Test 4: log2=1, continuous valid_i of 1024, then 3072, repeating -> valid_o every 2nd cycle with data_o=2, and no sample lost across the DUMP cycle.
REQ-032 Test 5: log2=3, clear_i after 5 samples, then 8 samples of 1024 -> exactly one valid_o, data_o=1; with the macro, inputs at the max positive value saturate to 0x7FFFFFFF.
REQ-033 Test 6: rst_ni pulsed low after 3 of 4 samples -> outputs zero immediately; the next 4 samples of 2048 -> data_o=2.

Source files
------------

// File: rtl/mixer_decimator_pkg.sv
// Shared definitions for the mixer decimator: block state encoding and
// accumulator sizing. Optional rounding feature: MIXER_DECIMATOR_ROUND_EN.
package mixer_decimator_pkg;

   // ACCUM: summing samples of the current block; DUMP: result cycle
   typedef enum logic {
      ACCUM = 1'b0,
      DUMP  = 1'b1
   } dec_state_e;

   // A sum of 2^lmax samples of win bits never needs more than win+lmax bits
   function automatic int acc_width(input int win, input int lmax);
      return win + lmax;
   endfunction

endpackage

// File: rtl/decim_round.sv
// Final scaling stage: drops the LSBs of the block average down to the
// output width. With MIXER_DECIMATOR_ROUND_EN defined it rounds half up and
// saturates; otherwise it is a pure truncating slice (floor).
module decim_round #(
   parameter int WIDTH_IN  = 42,
   parameter int WIDTH_OUT = 32
) (
   input  logic signed [WIDTH_IN-1:0]  i_avg,
   output logic signed [WIDTH_OUT-1:0] o_res
);

   localparam int DROP = WIDTH_IN - WIDTH_OUT;

`ifdef MIXER_DECIMATOR_ROUND_EN
   generate
      if (DROP == 0) begin : g_nodrop
         assign o_res = i_avg;
      end else begin : g_round
         localparam logic signed [WIDTH_IN:0] BIAS = (WIDTH_IN+1)'(1) << (DROP-1);
         localparam logic signed [WIDTH_OUT-1:0] SMAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
         localparam logic signed [WIDTH_OUT-1:0] SMIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};
         logic signed [WIDTH_IN:0]  w_rnd;
         logic signed [WIDTH_OUT:0] w_q;
         logic                      w_unused_lo;

         // One guard bit so the half-LSB bias cannot wrap
         assign w_rnd       = {i_avg[WIDTH_IN-1], i_avg} + BIAS;
         assign w_q         = w_rnd[WIDTH_IN:DROP];
         assign w_unused_lo = ^w_rnd[DROP-1:0];

         // Clamp when the guard bit disagrees with the output sign bit
         always_comb begin
            o_res = w_q[WIDTH_OUT-1:0];
            if (w_q[WIDTH_OUT] != w_q[WIDTH_OUT-1])
               o_res = w_q[WIDTH_OUT] ? SMIN : SMAX;
         end
      end
   endgenerate
`else
   assign o_res = i_avg[WIDTH_IN-1 -: WIDTH_OUT];
   generate
      if (DROP > 0) begin : g_sink
         logic w_unused_lo;
         assign w_unused_lo = ^i_avg[DROP-1:0];
      end
   endgenerate
`endif

endmodule

// File: rtl/mixer_decimator.sv
// Block-averaging decimator for a mixer product stream. Sums N = 2^k
// accepted samples, divides by N with an arithmetic shift and presents the
// scaled result for one cycle. Optional rounding/saturation in the output
// stage is enabled by defining MIXER_DECIMATOR_ROUND_EN.
module mixer_decimator
   import mixer_decimator_pkg::*;
#(
   parameter int WIDTH_IN       = 42,
   parameter int WIDTH_OUT      = 32,   // must not exceed WIDTH_IN
   parameter int LOG2_MAX_DECIM = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic signed [WIDTH_IN-1:0]  data_i,
   input  logic                        valid_i,
   input  logic        [4:0]           log2_decim_i,
   input  logic                        clear_i,
   output logic signed [WIDTH_OUT-1:0] data_o,
   output logic                        valid_o
);

   localparam int ACC_W = acc_width(WIDTH_IN, LOG2_MAX_DECIM);
   localparam int CNT_W = LOG2_MAX_DECIM + 1;
   localparam logic [4:0] LMAX = 5'(LOG2_MAX_DECIM);

   dec_state_e                r_state, w_state_nxt;
   logic        [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic signed [ACC_W-1:0]   r_acc, w_acc_nxt;
   logic        [4:0]         r_log2, w_log2_nxt;
   logic signed [WIDTH_OUT-1:0] r_data;
   logic                      r_valid;

   logic                      w_first;
   logic        [4:0]         w_log2_in;
   logic        [4:0]         w_log2n;
   logic signed [ACC_W-1:0]   w_din_ext;
   logic signed [ACC_W-1:0]   w_sum;
   logic signed [ACC_W-1:0]   w_shifted;
   logic        [CNT_W-1:0]   w_cnt_inc;
   logic        [CNT_W-1:0]   w_target;
   logic                      w_fire;
   logic signed [WIDTH_OUT-1:0] w_res;
   logic                      w_unused_hi;

   // A block starts whenever the counter is empty; the ratio is sampled then
   assign w_first   = (r_cnt == '0);
   assign w_log2_in = (log2_decim_i > LMAX) ? LMAX : log2_decim_i;
   assign w_log2n   = w_first ? w_log2_in : r_log2;
   assign w_din_ext = {{LOG2_MAX_DECIM{data_i[WIDTH_IN-1]}}, data_i};
   assign w_sum     = (w_first ? '0 : r_acc) + w_din_ext;
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_target  = CNT_W'(1) << w_log2n;

   // The average of N samples always fits back into WIDTH_IN bits
   assign w_shifted   = w_sum >>> w_log2n;
   assign w_unused_hi = ^w_shifted[ACC_W-1:WIDTH_IN];

   decim_round #(
      .WIDTH_IN  (WIDTH_IN),
      .WIDTH_OUT (WIDTH_OUT)
   ) u_round (
      .i_avg (w_shifted[WIDTH_IN-1:0]),
      .o_res (w_res)
   );

   // Next-state logic: accumulate, complete a block, or flush on clear
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc_nxt   = r_acc;
      w_log2_nxt  = r_log2;
      w_fire      = 1'b0;
      if (r_state == DUMP)
         w_state_nxt = ACCUM;
      if (clear_i) begin
         w_state_nxt = ACCUM;
         w_cnt_nxt   = '0;
         w_acc_nxt   = '0;
      end else if (valid_i) begin
         w_log2_nxt = w_log2n;
         if (w_cnt_inc == w_target) begin
            // N-th sample: result goes out next cycle, block restarts empty
            w_fire      = 1'b1;
            w_state_nxt = DUMP;
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
         end else begin
            w_cnt_nxt = w_cnt_inc;
            w_acc_nxt = w_sum;
         end
      end
   end

   // State, counter, accumulator and latched ratio registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ACCUM;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_log2  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_acc   <= w_acc_nxt;
         r_log2  <= w_log2_nxt;
      end
   end

   // Output register: strobe for one cycle, data held until the next strobe
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_fire;
         if (w_fire)
            r_data <= w_res;
      end
   end

   assign data_o  = r_data;
   assign valid_o = r_valid;

endmodule

// File: tb/tb_mixer_decimator.sv
// Directed bench for mixer_decimator with a sample-list reference model.
module tb_mixer_decimator;

   localparam int WI   = 42;
   localparam int WO   = 32;
   localparam int DROP = WI - WO;

   logic                 clk_i;
   logic                 rst_ni;
   logic signed [WI-1:0] data_i;
   logic                 valid_i;
   logic [4:0]           log2_decim_i;
   logic                 clear_i;
   logic signed [WO-1:0] data_o;
   logic                 valid_o;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   // reference model: samples of the current block, expected outputs
   longint blk_q[$];
   int     blk_l2;
   bit     exp_valid;
   longint exp_data;
   int     pulses;

   mixer_decimator dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .data_i       (data_i),
      .valid_i      (valid_i),
      .log2_decim_i (log2_decim_i),
      .clear_i      (clear_i),
      .data_o       (data_o),
      .valid_o      (valid_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // mean of the block (floor), then scale to the output width
   function automatic longint scale(input longint sum, input int l2);
      longint avg, r;
      avg = sum >>> l2;
`ifdef MIXER_DECIMATOR_ROUND_EN
      r = (avg + (longint'(1) << (DROP-1))) >>> DROP;
      if (r > 64'sd2147483647)  r = 64'sd2147483647;
      if (r < -64'sd2147483648) r = -64'sd2147483648;
`else
      r = avg >>> DROP;
`endif
      return r;
   endfunction

   task automatic model_reset();
      blk_q.delete();
      blk_l2    = 0;
      exp_valid = 0;
      exp_data  = 0;
   endtask

   task automatic model_edge(input bit v, input longint d, input int l, input bit c);
      longint s;
      exp_valid = 0;
      if (c) blk_q.delete();
      else if (v) begin
         if (blk_q.size() == 0) blk_l2 = (l > 16) ? 16 : l;
         blk_q.push_back(d);
         if (blk_q.size() == (1 << blk_l2)) begin
            s = 0;
            foreach (blk_q[i]) s += blk_q[i];
            exp_data  = scale(s, blk_l2);
            exp_valid = 1;
            blk_q.delete();
         end
      end
   endtask

   task automatic step(input bit v, input longint d, input int l, input bit c);
      valid_i      = v;
      data_i       = WI'(d);
      log2_decim_i = 5'(l);
      clear_i      = c;
      @(posedge clk_i);
      model_edge(v, d, l, c);
      #1;
      pulses += int'(valid_o);
   endtask

   // every-cycle comparison against the model
   always @(negedge clk_i) begin
      if (chk_en) begin
         chk("cmp_valid", longint'(valid_o), longint'(exp_valid));
         chk("cmp_data", longint'(data_o), exp_data);
      end
   end

   initial begin
      longint maxp, minn;
      maxp = (longint'(1) <<< (WI-1)) - 1;
      minn = -(longint'(1) <<< (WI-1));
      rst_ni = 1'b1; valid_i = 0; data_i = '0; log2_decim_i = '0; clear_i = 0;
      pulses = 0;
      model_reset();
      #1 rst_ni = 1'b0;
      chk_en = 1;
      @(posedge clk_i); @(posedge clk_i); #1;
      chk("reset_valid", longint'(valid_o), 0);
      chk("reset_data", longint'(data_o), 0);
      rst_ni = 1'b1;

      // Test 1 / 2: N=4 exact averages
      for (int i = 0; i < 4; i++) step(1, 5120, 2, 0);
      chk("t1_valid", longint'(valid_o), 1);
      chk("t1_data", longint'(data_o), 5);
      step(0, 0, 2, 0);
      chk("t1_one_pulse", longint'(valid_o), 0);
      for (int i = 0; i < 4; i++) step(1, -5120, 2, 0);
      chk("t2_data", longint'(data_o), -5);

      // Test 3: N=1, half-LSB inputs
      step(1, 1536, 0, 0);
`ifdef MIXER_DECIMATOR_ROUND_EN
      chk("t3_pos", longint'(data_o), 2);
`else
      chk("t3_pos", longint'(data_o), 1);
`endif
      step(1, -1536, 0, 0);
      chk("t3_cont_valid", longint'(valid_o), 1);
`ifdef MIXER_DECIMATOR_ROUND_EN
      chk("t3_neg", longint'(data_o), -1);
`else
      chk("t3_neg", longint'(data_o), -2);
`endif

      // Test 4: N=2 at full rate, alternating 1024/3072
      pulses = 0;
      for (int i = 0; i < 8; i++) step(1, (i % 2 == 0) ? 1024 : 3072, 1, 0);
      chk("t4_pulses", pulses, 4);
      chk("t4_data", longint'(data_o), 2);

      // ratio change mid-block only applies to the next block
      step(1, 4096, 1, 0);
      step(1, 4096, 2, 0);
      chk("ratio_latched", longint'(data_o), 4);
      // idle gaps inside a block
      step(1, 2048, 2, 0);
      step(0, 99999, 2, 0);
      step(0, 99999, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 2048, 0, 0);
      chk("gap_data", longint'(data_o), 2);

      // Test 5: clear after 5 samples, valid with clear discarded
      pulses = 0;
      for (int i = 0; i < 5; i++) step(1, 9999 * 1024, 3, 0);
      step(1, 77777, 3, 1);
      for (int i = 0; i < 8; i++) step(1, 1024, 3, 0);
      chk("t5_pulses", pulses, 1);
      chk("t5_data", longint'(data_o), 1);
      for (int i = 0; i < 8; i++) step(1, maxp, 3, 0);
      chk("t5_maxpos", longint'(data_o), 64'sd2147483647);
      for (int i = 0; i < 8; i++) step(1, minn, 3, 0);
      chk("t5_minneg", longint'(data_o), -64'sd2147483648);
      // clear coinciding with the completing sample suppresses the strobe
      pulses = 0;
      step(1, 8192, 1, 0);
      step(1, 8192, 1, 1);
      step(0, 0, 1, 0);
      chk("clear_suppress", pulses, 0);

      // Test 6: asynchronous reset mid-block
      for (int i = 0; i < 3; i++) step(1, 7 * 1024, 2, 0);
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_valid", longint'(valid_o), 0);
      chk("t6_rst_data", longint'(data_o), 0);
      model_reset();
      #1 rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) step(1, 2048, 2, 0);
      chk("t6_data", longint'(data_o), 2);

      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      @(negedge clk_i); #1;
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
